// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
// Latency: none (types, constants and elaboration-time functions only).
// Backpressure: not applicable.
package keypad_pkg;

    // Press-tracking FSM states.
    typedef enum logic {
        IDLE    = 1'b0,
        PRESSED = 1'b1
    } kp_state_t;

    // Frame code meaning "no key" (zero or several keys seen in a frame).
    localparam int CODE_NONE = 0;

    // Codes run 0..n_keys, so one extra value beyond the key count is needed.
    function automatic int code_width(input int n_keys);
        return $clog2(n_keys + 1);
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Synchronous show-ahead FIFO: dout always presents the head entry.
// Latency: a pushed entry is visible on dout the cycle after the push edge.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
// Ports: clock_in/reset_in (async, active-high); push/din write; pop advances head;
//        dout head data (undefined while empty); empty/full status.
module key_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clock_in,
    input  logic             reset_in,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        pop_ok   = pop & ~empty;
        // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
        push_ok  = push & (~full | pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: contents are only observed behind the pointers.
    always_ff @(posedge clock_in) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning matrix keypad reader with frame debounce and a key-code queue.
// Latency: code queued on the edge ending the DEBOUNCE-th identical frame; valid next cycle.
// Backpressure: key_rd_in pops the queue; presses arriving while it is full are dropped (sticky overflow_out).
// Ports: clock_in/reset_in (async, active-high); linha_out one-hot row drive; coluna_in column sense;
//        key_code_out/key_valid_out/key_rd_in queue head and pop; key_pressed_out, multi_key_out, overflow_out status.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter  int N_ROWS     = 3,
    parameter  int N_COLS     = 3,
    parameter  int SCAN_DIV   = 1000,
    parameter  int DEBOUNCE   = 16,
    parameter  int FIFO_DEPTH = 4,
    localparam int CODE_W     = code_width(N_ROWS * N_COLS)
) (
    input  logic              clock_in,
    input  logic              reset_in,
    output logic [N_ROWS-1:0] linha_out,
    input  logic [N_COLS-1:0] coluna_in,
    output logic [CODE_W-1:0] key_code_out,
    output logic              key_valid_out,
    input  logic              key_rd_in,
    output logic              key_pressed_out,
    output logic              multi_key_out,
    output logic              overflow_out
);
    localparam int DWELL_W = $clog2(SCAN_DIV);
    localparam int ROW_W   = $clog2(N_ROWS);
    localparam int STAB_W  = $clog2(DEBOUNCE);

    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [1:0]         hits_q, hits_d;          // keys seen so far this frame, saturating at 2
    logic [CODE_W-1:0]  hit_code_q, hit_code_d;  // code of the first key seen this frame
    logic [CODE_W-1:0]  prev_code_q, prev_code_d;
    logic [STAB_W-1:0]  stab_cnt_q, stab_cnt_d;
    logic [CODE_W-1:0]  held_code_q, held_code_d;
    kp_state_t          state_q, state_d;
    logic               multi_q, multi_d;
    logic               overflow_q, overflow_d;

    logic               last_dwell, frame_end, stable;
    logic [1:0]         row_hits, total_hits;
    logic [2:0]         hit_sum;
    logic [CODE_W-1:0]  row_code, frame_code;
    logic               push_req, pop_req;
    logic               fifo_empty, fifo_full;
    logic [CODE_W-1:0]  fifo_dout;
    int                 n_set, col_idx;

    assign last_dwell = (dwell_q == DWELL_W'(SCAN_DIV - 1));
    assign frame_end  = last_dwell && (row_q == ROW_W'(N_ROWS - 1));

    // Decode the columns sampled for the currently driven row.
    always_comb begin
        n_set   = 0;
        col_idx = 0;
        for (int c = N_COLS - 1; c >= 0; c--) begin
            if (coluna_in[c]) begin
                n_set   = n_set + 1;
                col_idx = c;
            end
        end
        row_hits   = (n_set == 0) ? 2'd0 : (n_set == 1) ? 2'd1 : 2'd2;
        row_code   = CODE_W'(int'(row_q) * N_COLS + col_idx + 1);
        hit_sum    = {1'b0, hits_q} + {1'b0, row_hits};
        total_hits = (hit_sum > 3'd1) ? 2'd2 : hit_sum[1:0];
        // Only meaningful on the frame's final sample edge.
        if (total_hits == 2'd1) begin
            frame_code = (hits_q == 2'd1) ? hit_code_q : row_code;
        end else begin
            frame_code = CODE_W'(CODE_NONE);
        end
    end

    always_comb begin
        dwell_d     = dwell_q + DWELL_W'(1);
        row_d       = row_q;
        hits_d      = hits_q;
        hit_code_d  = hit_code_q;
        prev_code_d = prev_code_q;
        stab_cnt_d  = stab_cnt_q;
        held_code_d = held_code_q;
        state_d     = state_q;
        multi_d     = multi_q;
        stable      = 1'b0;
        push_req    = 1'b0;

        if (last_dwell) begin
            dwell_d = '0;
            row_d   = frame_end ? '0 : row_q + ROW_W'(1);
            if (frame_end) begin
                hits_d     = '0;
                hit_code_d = '0;
                multi_d    = (total_hits == 2'd2);
                if (frame_code == prev_code_q) begin
                    if (stab_cnt_q != STAB_W'(DEBOUNCE - 1)) begin
                        stab_cnt_d = stab_cnt_q + STAB_W'(1);
                    end
                end else begin
                    stab_cnt_d  = '0;
                    prev_code_d = frame_code;
                end
                // The FSM acts on this frame's updated count so the push lands on this same edge.
                stable = (stab_cnt_d == STAB_W'(DEBOUNCE - 1));
                case (state_q)
                    IDLE: begin
                        if (stable && frame_code != CODE_W'(CODE_NONE)) begin
                            push_req    = 1'b1;
                            held_code_d = frame_code;
                            state_d     = PRESSED;
                        end
                    end
                    PRESSED: begin
                        if (stable && frame_code == CODE_W'(CODE_NONE)) begin
                            held_code_d = '0;
                            state_d     = IDLE;
                        end else if (stable && frame_code != held_code_q) begin
                            // Roll-over onto a different key queues the new code.
                            push_req    = 1'b1;
                            held_code_d = frame_code;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end else begin
                hits_d = total_hits;
                if (hits_q == 2'd0 && row_hits == 2'd1) begin
                    hit_code_d = row_code;
                end
            end
        end
    end

    assign pop_req    = key_rd_in & ~fifo_empty;
    assign overflow_d = overflow_q | (push_req & fifo_full & ~pop_req);

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            dwell_q     <= '0;
            row_q       <= '0;
            hits_q      <= '0;
            hit_code_q  <= '0;
            prev_code_q <= '0;
            stab_cnt_q  <= '0;
            held_code_q <= '0;
            state_q     <= IDLE;
            multi_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            dwell_q     <= dwell_d;
            row_q       <= row_d;
            hits_q      <= hits_d;
            hit_code_q  <= hit_code_d;
            prev_code_q <= prev_code_d;
            stab_cnt_q  <= stab_cnt_d;
            held_code_q <= held_code_d;
            state_q     <= state_d;
            multi_q     <= multi_d;
            overflow_q  <= overflow_d;
        end
    end

    key_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_key_fifo (
        .clock_in (clock_in),
        .reset_in (reset_in),
        .push     (push_req),
        .pop      (pop_req),
        .din      (frame_code),
        .dout     (fifo_dout),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign linha_out       = N_ROWS'(1) << row_q;
    assign key_valid_out   = ~fifo_empty;
    assign key_code_out    = fifo_empty ? CODE_W'(CODE_NONE) : fifo_dout;
    assign key_pressed_out = (state_q == PRESSED);
    assign multi_key_out   = multi_q;
    assign overflow_out    = overflow_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a 3x3 keypad model, SCAN_DIV=4, DEBOUNCE=3 (12-clock frames).
// Latency: not applicable.
// Backpressure: not applicable.
module tb_keypad_scanner;
    logic       clock_in = 1'b0;
    logic       reset_in;
    logic [2:0] linha_out;
    logic [2:0] coluna_in;
    logic [3:0] key_code_out;
    logic       key_valid_out;
    logic       key_rd_in;
    logic       key_pressed_out;
    logic       multi_key_out;
    logic       overflow_out;

    logic [8:0] key_map;   // bit r*3+c = key at row r, col c held down
    int         edge_n;    // rising edges since reset release
    int         n_checks = 0;
    int         n_fail   = 0;

    keypad_scanner #(
        .N_ROWS     (3),
        .N_COLS     (3),
        .SCAN_DIV   (4),
        .DEBOUNCE   (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clock_in        (clock_in),
        .reset_in        (reset_in),
        .linha_out       (linha_out),
        .coluna_in       (coluna_in),
        .key_code_out    (key_code_out),
        .key_valid_out   (key_valid_out),
        .key_rd_in       (key_rd_in),
        .key_pressed_out (key_pressed_out),
        .multi_key_out   (multi_key_out),
        .overflow_out    (overflow_out)
    );

    always #5 clock_in = ~clock_in;

    // Passive matrix: a held key connects its row line to its column line.
    always_comb begin
        coluna_in = 3'b000;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (key_map[r*3+c] && linha_out[r]) coluna_in[c] = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock_in);
            edge_n = edge_n + 1;
        end
        #1;
    endtask

    task automatic goto_edge(input int n);
        tick(n - edge_n);
    endtask

    task automatic press(input int code);
        key_map = 9'd1 << (code - 1);
    endtask

    task automatic pop_one();
        key_rd_in = 1'b1;
        tick(1);
        key_rd_in = 1'b0;
    endtask

    task automatic do_reset();
        reset_in  = 1'b1;
        key_map   = '0;
        key_rd_in = 1'b0;
        repeat (2) @(posedge clock_in);
        @(negedge clock_in);
        reset_in = 1'b0;
        edge_n   = 0;
    endtask

    task automatic test_reset();
        reset_in  = 1'b1;
        key_map   = '0;
        key_rd_in = 1'b0;
        #12;
        n_checks++; if (linha_out !== 3'b001) begin n_fail++; $display("FAIL reset_linha: got %b want 001", linha_out); end
        n_checks++; if (key_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", key_valid_out); end
        n_checks++; if (key_code_out !== 4'd0) begin n_fail++; $display("FAIL reset_code: got %0d want 0", key_code_out); end
        n_checks++; if (key_pressed_out !== 1'b0) begin n_fail++; $display("FAIL reset_pressed: got %b want 0", key_pressed_out); end
        n_checks++; if (multi_key_out !== 1'b0) begin n_fail++; $display("FAIL reset_multi: got %b want 0", multi_key_out); end
        n_checks++; if (overflow_out !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow_out); end
    endtask

    task automatic test_idle_scan();
        logic [2:0] exp_row;
        do_reset();
        for (int k = 1; k <= 60; k++) begin
            tick(1);
            exp_row = 3'b001 << ((k / 4) % 3);
            n_checks++; if (linha_out !== exp_row) begin n_fail++; $display("FAIL idle_linha edge %0d: got %b want %b", k, linha_out, exp_row); end
            n_checks++; if (key_valid_out !== 1'b0 || key_code_out !== 4'd0) begin n_fail++; $display("FAIL idle_queue edge %0d: got valid %b code %0d want 0/0", k, key_valid_out, key_code_out); end
        end
    endtask

    task automatic test_single_press();
        do_reset();
        press(6);                       // row 1, col 2
        goto_edge(35);
        n_checks++; if (key_valid_out !== 1'b0) begin n_fail++; $display("FAIL press_early_valid: got %b want 0", key_valid_out); end
        n_checks++; if (key_pressed_out !== 1'b0) begin n_fail++; $display("FAIL press_early_pressed: got %b want 0", key_pressed_out); end
        goto_edge(36);
        n_checks++; if (key_valid_out !== 1'b1) begin n_fail++; $display("FAIL press_valid_rise: got %b want 1", key_valid_out); end
        n_checks++; if (key_code_out !== 4'd6) begin n_fail++; $display("FAIL press_code: got %0d want 6", key_code_out); end
        n_checks++; if (key_pressed_out !== 1'b1) begin n_fail++; $display("FAIL press_pressed: got %b want 1", key_pressed_out); end
        goto_edge(72);
        key_map = '0;
        pop_one();
        n_checks++; if (key_valid_out !== 1'b0) begin n_fail++; $display("FAIL press_single_push: got valid %b want 0", key_valid_out); end
        goto_edge(96);
        n_checks++; if (key_pressed_out !== 1'b1) begin n_fail++; $display("FAIL release_early: got pressed %b want 1", key_pressed_out); end
        goto_edge(108);
        n_checks++; if (key_pressed_out !== 1'b0) begin n_fail++; $display("FAIL release_pressed: got %b want 0", key_pressed_out); end
        n_checks++; if (key_valid_out !== 1'b0) begin n_fail++; $display("FAIL release_no_push: got valid %b want 0", key_valid_out); end
    endtask

    task automatic test_multi_key();
        do_reset();
        key_map = 9'b010000001;         // (0,0) and (2,1)
        goto_edge(12);
        n_checks++; if (multi_key_out !== 1'b1) begin n_fail++; $display("FAIL multi_flag: got %b want 1", multi_key_out); end
        goto_edge(36);
        n_checks++; if (key_valid_out !== 1'b0 || key_pressed_out !== 1'b0) begin n_fail++; $display("FAIL multi_no_push: got valid %b pressed %b want 0/0", key_valid_out, key_pressed_out); end
        press(1);
        goto_edge(47);
        n_checks++; if (multi_key_out !== 1'b1) begin n_fail++; $display("FAIL multi_hold: got %b want 1", multi_key_out); end
        goto_edge(48);
        n_checks++; if (multi_key_out !== 1'b0) begin n_fail++; $display("FAIL multi_clear: got %b want 0", multi_key_out); end
        goto_edge(71);
        n_checks++; if (key_valid_out !== 1'b0) begin n_fail++; $display("FAIL multi_early_push: got valid %b want 0", key_valid_out); end
        goto_edge(72);
        n_checks++; if (key_valid_out !== 1'b1 || key_code_out !== 4'd1) begin n_fail++; $display("FAIL multi_release_push: got valid %b code %0d want 1/1", key_valid_out, key_code_out); end
    endtask

    task automatic test_bounce();
        do_reset();
        press(5);
        goto_edge(12); key_map = '0;
        goto_edge(24); press(5);
        goto_edge(36); key_map = '0;
        goto_edge(48); press(5);
        n_checks++; if (key_valid_out !== 1'b0) begin n_fail++; $display("FAIL bounce_toggle_push: got valid %b want 0", key_valid_out); end
        goto_edge(83);
        n_checks++; if (key_valid_out !== 1'b0) begin n_fail++; $display("FAIL bounce_early: got valid %b want 0", key_valid_out); end
        goto_edge(84);
        n_checks++; if (key_valid_out !== 1'b1 || key_code_out !== 4'd5) begin n_fail++; $display("FAIL bounce_push: got valid %b code %0d want 1/5", key_valid_out, key_code_out); end
        pop_one();
        n_checks++; if (key_valid_out !== 1'b0) begin n_fail++; $display("FAIL bounce_single: got valid %b want 0", key_valid_out); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) goto_edge(36 * (k - 1));
            press(k);
        end
        goto_edge(179);
        n_checks++; if (overflow_out !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", overflow_out); end
        goto_edge(180);
        n_checks++; if (overflow_out !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow_out); end
        key_map = '0;
        for (int i = 1; i <= 4; i++) begin
            n_checks++; if (key_valid_out !== 1'b1 || key_code_out !== 4'(i)) begin n_fail++; $display("FAIL ovf_pop%0d: got valid %b code %0d want 1/%0d", i, key_valid_out, key_code_out, i); end
            pop_one();
        end
        n_checks++; if (key_valid_out !== 1'b0 || key_code_out !== 4'd0) begin n_fail++; $display("FAIL ovf_drained: got valid %b code %0d want 0/0", key_valid_out, key_code_out); end
        n_checks++; if (overflow_out !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow_out); end
        pop_one();
        n_checks++; if (key_valid_out !== 1'b0 || key_code_out !== 4'd0) begin n_fail++; $display("FAIL empty_pop: got valid %b code %0d want 0/0", key_valid_out, key_code_out); end
    endtask

    task automatic test_back_to_back();
        // One queued entry: push and pop on the same edge moves the head to the new code.
        do_reset();
        press(1);
        goto_edge(36); press(2);
        goto_edge(71);
        pop_one();
        n_checks++; if (key_valid_out !== 1'b1 || key_code_out !== 4'd2) begin n_fail++; $display("FAIL b2b_one_entry: got valid %b code %0d want 1/2", key_valid_out, key_code_out); end
        pop_one();
        n_checks++; if (key_valid_out !== 1'b0) begin n_fail++; $display("FAIL b2b_one_drain: got valid %b want 0", key_valid_out); end
        // Full queue: push and pop on the same edge both succeed without overflow.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) goto_edge(36 * (k - 1));
            press(k);
        end
        goto_edge(179);
        pop_one();
        n_checks++; if (overflow_out !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ovf: got %b want 0", overflow_out); end
        key_map = '0;
        for (int i = 2; i <= 5; i++) begin
            n_checks++; if (key_valid_out !== 1'b1 || key_code_out !== 4'(i)) begin n_fail++; $display("FAIL b2b_full_pop%0d: got valid %b code %0d want 1/%0d", i, key_valid_out, key_code_out, i); end
            pop_one();
        end
        n_checks++; if (key_valid_out !== 1'b0) begin n_fail++; $display("FAIL b2b_full_drain: got valid %b want 0", key_valid_out); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        key_map = 9'b010000001;         // set multi_key_out first
        goto_edge(12); press(1);
        goto_edge(48); press(2);
        goto_edge(88);
        n_checks++; if (key_valid_out !== 1'b1 || key_code_out !== 4'd1 || key_pressed_out !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got valid %b code %0d pressed %b want 1/1/1", key_valid_out, key_code_out, key_pressed_out); end
        pop_one();
        n_checks++; if (key_code_out !== 4'd2) begin n_fail++; $display("FAIL mid_pre_second: got code %0d want 2", key_code_out); end
        press(3);
        goto_edge(120);
        #2 reset_in = 1'b1;
        #1;
        n_checks++; if (linha_out !== 3'b001) begin n_fail++; $display("FAIL mid_linha: got %b want 001", linha_out); end
        n_checks++; if (key_valid_out !== 1'b0 || key_code_out !== 4'd0) begin n_fail++; $display("FAIL mid_queue: got valid %b code %0d want 0/0", key_valid_out, key_code_out); end
        n_checks++; if (key_pressed_out !== 1'b0 || multi_key_out !== 1'b0 || overflow_out !== 1'b0) begin n_fail++; $display("FAIL mid_status: got pressed %b multi %b ovf %b want 0/0/0", key_pressed_out, multi_key_out, overflow_out); end
        key_map = '0;
        @(negedge clock_in);
        reset_in = 1'b0;
        edge_n   = 0;
        goto_edge(24);
        n_checks++; if (key_valid_out !== 1'b0 || key_code_out !== 4'd0) begin n_fail++; $display("FAIL mid_after: got valid %b code %0d want 0/0", key_valid_out, key_code_out); end
    endtask

    initial begin
        edge_n = 0;
        test_reset();
        test_idle_scan();
        test_single_press();
        test_multi_key();
        test_bounce();
        test_overflow();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Parametrised successor to the team's 3x3 keypad decoder. The block actively scans an N_ROWS x N_COLS matrix keypad by driving one row at a time and sampling the column lines. It debounces on whole scan frames, detects and rejects multi-key presses, and queues one code per debounced press in a small FIFO with a ready/read handshake. It sits between the board keypad pins and the control FSM that consumes the turn count (numgiro).

Parameters:
N_ROWS, 3, number of keypad rows (driven lines), 2..8
N_COLS, 3, number of keypad columns (sensed lines), 2..8
SCAN_DIV, 1000, clocks each row is held driven before moving to the next row, >=2
DEBOUNCE, 16, consecutive identical frames required for a stable code, >=2
FIFO_DEPTH, 4, key queue entries, power of two, >=2
CODE_W, clog2(N_ROWS*N_COLS+1), key code width (derived, not overridden)

Ports:
clock_in  in  1  system clock
reset_in  in  1  reset, asynchronous, active-high
linha_out  out  N_ROWS  one-hot row drive, active-high
coluna_in  in  N_COLS  column sense, active-high, already synchronised externally
key_code_out  out  CODE_W  FIFO head code; 0 when FIFO empty
key_valid_out  out  1  FIFO not empty
key_rd_in  in  1  pop request; honoured only when key_valid_out=1
key_pressed_out  out  1  debounced key currently held
multi_key_out  out  1  last completed frame saw more than one key
overflow_out  out  1  sticky; a press was dropped because the FIFO was full

Behaviour:
- Reset (async):
  - row index=0, linha_out=1 (row 0), all counters=0, FSM=IDLE, FIFO empty.
  - key_code_out=0, key_valid_out=0, key_pressed_out=0, multi_key_out=0, overflow_out=0.
- Scan:
  - Dwell counter runs 0..SCAN_DIV-1.
  - coluna_in is sampled only on the dwell's last cycle (settle time). On that same edge the row index advances, wrapping N_ROWS-1 -> 0.
  - One frame = N_ROWS*SCAN_DIV clocks.
- Frame code, evaluated at the end of the frame (the last row's sample edge):
  - Count asserted bits across all row samples.
  - Exactly 1 bit at row r, col c -> code = r*N_COLS + c + 1 (row 0 col 0 = 1). This matches the legacy mapping of 1..9 for 3x3.
  - 0 bits -> code 0.
  - More than 1 bit -> code 0, and multi_key_out=1 for that frame (updated every frame).
- Debounce:
  - prev_code register. Equal frame code -> stab_cnt increments, saturating at DEBOUNCE-1. Different code -> stab_cnt=0 and prev_code=new code.
  - stable = (stab_cnt == DEBOUNCE-1).
- FSM, states IDLE and PRESSED:
  - IDLE, stable and code!=0 -> push code, go to PRESSED.
  - PRESSED, stable and code==0 -> IDLE.
  - PRESSED, stable and code != held code -> push new code, stay PRESSED (roll-over).
  - PRESSED, stable and same code -> no action (no auto-repeat).
  - key_pressed_out=1 exactly while in PRESSED.
- Latency: the push occurs on the edge that ends frame number DEBOUNCE with an identical code. key_valid_out rises on the next cycle.
- FIFO (show-ahead):
  - Pop on key_rd_in & key_valid_out. key_rd_in while empty is ignored.
  - Push when full without a same-cycle pop -> entry dropped, overflow_out=1 until reset.
  - Push and pop in the same cycle when full -> both succeed, no overflow.
  - Push and pop in the same cycle when holding one entry -> the head advances to the new entry.
- Mid-operation reset: everything above returns to reset values on the asserting edge. Queued codes are discarded.

Decomposition:
- Package keypad_pkg:
  - FSM enum {IDLE, PRESSED}.
  - clog2-based CODE_W function.
  - CODE_NONE=0 constant.
- Sub-module key_fifo: synchronous show-ahead FIFO parametrised on WIDTH and DEPTH. Ports push, pop, din, dout, empty, full. Pointers carry one extra wrap bit.
- Scan, frame logic and debounce stay in keypad_scanner.

Test Plan:
- Test configuration for all scenarios: N_ROWS=3, N_COLS=3, SCAN_DIV=4, DEBOUNCE=3, FIFO_DEPTH=4 (frame = 12 clocks).
- Idle, no keys for 60 clocks -> linha_out cycles 001, 010, 100 every 4 clocks; key_valid_out stays 0; key_code_out=0.
- Hold key at row 1, col 2 for 6 frames -> exactly one push with code 6. key_valid_out rises 1 clock after the end of frame 3. key_pressed_out=1. Releasing for 3 frames -> key_pressed_out=0. No second push.
- Press rows 0 col 0 and 2 col 1 together -> multi_key_out=1, no push. Release the second key -> code 1 pushed after 3 stable frames.
- Bounce: toggle key 5 every frame for 4 frames, then hold -> a single push of 5 only after 3 identical frames. stab_cnt resets on each toggle.
- Five distinct presses with key_rd_in=0 -> FIFO holds 1,2,3,4 and overflow_out=1. Popping 4 times yields 1,2,3,4, then key_valid_out=0 and overflow_out stays 1.
- Assert reset_in mid-frame with 2 codes queued -> all outputs return to reset values asynchronously; the queue is empty afterwards.
